muldiv_sequencer: RTL and testbench

//   Multi-cycle sequencer for the MULT/DIV (funct 0x18/0x1A) operations in the MIPS datapath.

---
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/DIV unit for the MIPS datapath: one shift-add or restoring-subtract step per clock into HI/LO.
// Latency: done pulses WIDTH+2 edges after the accepting edge; start is ignored while busy; flush aborts RUN/FIX.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 op_div_q, op_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_a_q, neg_a_d;
    logic                 b_zero_q, b_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh, div_diff;
    logic                 div_qbit;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rmd, fix_hi, fix_lo;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: the multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

    // Divide: the dividend sits in acc_q[WIDTH-1:0]; quotient bits shift in from the right.
    assign div_sh   = {rem_q, acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_qbit = ~div_diff[WIDTH];

    assign prod   = neg_res_q ? -acc_q : acc_q;
    assign quot   = acc_q[WIDTH-1:0];
    assign rmd    = rem_q;
    assign fix_hi = !op_div_q ? prod[2*WIDTH-1:WIDTH] :
                    b_zero_q  ? a_raw_q :
                    neg_a_q   ? -rmd : rmd;
    assign fix_lo = !op_div_q ? prod[WIDTH-1:0] :
                    b_zero_q  ? {WIDTH{1'b1}} :
                    neg_res_q ? -quot : quot;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        op_div_d  = op_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = CNT_INIT;
                    op_div_d  = op_div;
                    neg_res_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_a_d   = is_signed & a[WIDTH-1];
                    a_raw_d   = a;
                    b_zero_d  = (b == '0);
                    rem_d     = '0;
                    dbz_d     = 1'b0;
                    if (op_div) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q[CW-1]) begin
                    // Counter wrapped past zero: all WIDTH steps are in, one settle cycle before FIX.
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (op_div_q) begin
                        rem_d            = div_qbit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], div_qbit};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    dbz_d   = op_div_q & b_zero_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            op_div_q  <= op_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, ignored start, flush and async reset.
module tb_muldiv_sequencer;
    localparam int W   = 32;
    localparam int LAT = 34;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_div = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_err = 0;
    int n_checks = 0;
    int n;
    int seen;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .is_signed(is_signed),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start for exactly one accepting edge; returns #1 after that edge.
    task automatic start_op(input logic d, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        op_div = d; is_signed = s; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic run_check(input string tag, input logic d, input logic s,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
        int cyc;
        start_op(d, s, av, bv);
        wait_done(cyc);
        chk({tag, "_lat"}, W'(cyc), W'(LAT));
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dbz"}, W'(div_by_zero), W'(edbz));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_dbz", W'(div_by_zero), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned MULT of all-ones, with busy check and a start during DONE that must be dropped
        start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulu_busy", W'(busy), W'(1));
        wait_done(n);
        chk("mulu_lat", W'(n), W'(LAT));
        chk("mulu_hi", hi, 32'hFFFF_FFFE);
        chk("mulu_lo", lo, 32'h0000_0001);
        start_op(1'b0, 1'b0, 32'd3, 32'd3);
        chk("start_in_done_ignored", W'(busy), W'(0));
        chk("mulu_hold_lo", lo, 32'h0000_0001);

        run_check("muls_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_check("mulu_pat", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
        run_check("divs_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("divs_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_check("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_check("divs_minneg", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_check("divu_by0", 1'b1, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_check("divs_by0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // div_by_zero clears when the next start is accepted
        start_op(1'b0, 1'b0, 32'h0001_0000, 32'h0003_0003);
        chk("dbz_clear", W'(div_by_zero), W'(0));
        // Pulse a second start mid-operation; it must not disturb or queue
        repeat (9) @(posedge clk);
        #1;
        start_op(1'b0, 1'b0, 32'd2, 32'd2);
        wait_done(n);
        chk("ign_lat", W'(n), W'(LAT - 10));
        chk("ign_hi", hi, 32'd3);
        chk("ign_lo", lo, 32'h0003_0000);
        count_done(40, seen);
        chk("ign_no_queue", W'(seen), W'(0));

        // Flush in RUN: no done, hi/lo keep the prior result
        start_op(1'b0, 1'b0, 32'd9, 32'd9);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", W'(busy), W'(0));
        count_done(50, seen);
        chk("flush_no_done", W'(seen), W'(0));
        chk("flush_hi", hi, 32'd3);
        chk("flush_lo", lo, 32'h0003_0000);

        // Flush together with start in IDLE: start wins
        flush = 1'b1;
        start_op(1'b0, 1'b0, 32'd6, 32'd7);
        flush = 1'b0;
        wait_done(n);
        chk("flush_start_lat", W'(n), W'(LAT));
        chk("flush_start_lo", lo, 32'd42);
        @(posedge clk); #1;

        // Async reset mid-RUN
        start_op(1'b0, 1'b0, 32'h1234_5678, 32'h10);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_done", W'(done), W'(0));
        chk("arst_hi", hi, '0);
        chk("arst_lo", lo, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_done(40, seen);
        chk("arst_no_done", W'(seen), W'(0));
        run_check("post_rst_div", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
